// File: rtl/barrel_pkg.sv
// Shared types and widths for the barrel-shift arbiter slice.
package barrel_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    // Controller states: wait for a request, run the shifter, hold the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // One accepted operation, captured at grant time.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              id;
    } operand_t;

endpackage

// File: rtl/barrel_shifter_8bit.sv
// Purely combinational 8-bit logical right barrel shifter (zero fill).
// Three log-steps of 1, 2 and 4 bit positions selected by ctrl.
module barrel_shifter_8bit
    import barrel_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [AMT_W-1:0]  ctrl,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] stage2;

    // Each stage either passes its input or shifts it by a power of two.
    always_comb begin
        stage1 = ctrl[0] ? {1'b0, in[7:1]}     : in;
        stage2 = ctrl[1] ? {2'b00, stage1[7:2]} : stage1;
        out    = ctrl[2] ? {4'h0, stage2[7:4]}  : stage2;
    end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two requesters share one barrel_shifter_8bit under round-robin arbitration.
// One operation is in flight at a time: IDLE (grant) -> SHIFT -> RESP.
// Optional per-requester completion counters: define BARREL_SHIFT_ARBITER_STATS_EN.
module barrel_shift_arbiter
    import barrel_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    output logic              busy
`ifdef BARREL_SHIFT_ARBITER_STATS_EN
    ,
    output logic [7:0]        stat0_cnt,
    output logic [7:0]        stat1_cnt
`endif
);

    state_t            state;
    logic              prio;
    logic              grant_any;
    logic              grant_id;
    operand_t          opnd;
    logic [DATA_W-1:0] shift_out;

    // Round-robin grant, only offered in IDLE and never while reset is held.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = prio;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;
    assign res_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    // FSM sequencing and priority hand-over after each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state <= IDLE;
            prio  <= RR_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state <= SHIFT;
                        prio  <= ~grant_id;
                    end
                end
                SHIFT:   state <= RESP;
                RESP:    if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the granted requester's operand for the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand register is cleared on reset so the shifter never propagates X into res_data, even though its value is don't-care in IDLE.
            opnd <= '0;
        end else if (grant_any) begin
            opnd.id   <= grant_id;
            opnd.data <= grant_id ? req1_data : req0_data;
            opnd.amt  <= grant_id ? req1_amt  : req0_amt;
        end
    end

    barrel_shifter_8bit u_shifter (
        .in   (opnd.data),
        .ctrl (opnd.amt),
        .out  (shift_out)
    );

    // Register the shifter result on the single SHIFT cycle; hold it through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_id   <= 1'b0;
        end else if (state == SHIFT) begin
            res_data <= shift_out;
            res_id   <= opnd.id;
        end
    end

`ifdef BARREL_SHIFT_ARBITER_STATS_EN
    // Saturating count of delivered results per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_cnt <= 8'd0;
            stat1_cnt <= 8'd0;
        end else if (res_valid && res_ready) begin
            if (res_id) begin
                if (stat1_cnt != 8'hFF) stat1_cnt <= stat1_cnt + 8'd1;
            end else begin
                if (stat0_cnt != 8'hFF) stat0_cnt <= stat0_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed self-checking bench for barrel_shift_arbiter (RR_INIT = 0).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_barrel_shift_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [2:0] req0_amt, req1_amt;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_id;
    logic       busy;
`ifdef BARREL_SHIFT_ARBITER_STATS_EN
    logic [7:0] stat0_cnt, stat1_cnt;
`endif

    int total;
    int passed;

    barrel_shift_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
`ifdef BARREL_SHIFT_ARBITER_STATS_EN
        ,
        .stat0_cnt  (stat0_cnt),
        .stat1_cnt  (stat1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for res_valid at falling edges; n = edges waited.
    task automatic wait_res(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (res_valid !== 1'b1 && n < 20);
        check({tag, "_timeout"}, {7'd0, res_valid}, 8'd1);
    endtask

    // One lone request from requester id, result consumed immediately.
    task automatic run_single(input string tag, input logic id, input logic [7:0] d,
                              input logic [2:0] a, input logic [7:0] exp);
        int n;
        res_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a;
        end
        wait_res(tag, n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_data"}, res_data, exp);
        check({tag, "_id"}, {7'd0, res_id}, {7'd0, id});
        @(negedge clk);
    endtask

    initial begin
        int n;
        total  = 0;
        passed = 0;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        req0_amt = 3'd0; req1_amt = 3'd0;
        res_ready = 1'b0;

        // Reset state, with a request pending that must not be accepted.
        @(negedge clk);
        @(negedge clk);
        check("rst_res_valid", {7'd0, res_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_res_data", res_data, 8'h00);
        check("rst_res_id", {7'd0, res_id}, 8'd0);
        check("rst_req0_ready", {7'd0, req0_ready}, 8'd0);

        // Single request: 0x80 >> 4 = 0x08, result two cycles after acceptance.
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 8'b1000_0000; req0_amt = 3'd4;
        res_ready = 1'b1;
        #1;
        check("single_req0_ready", {7'd0, req0_ready}, 8'd1);
        check("single_req1_ready", {7'd0, req1_ready}, 8'd0);
        @(negedge clk);
        check("single_shift_ready", {7'd0, req0_ready}, 8'd0);
        req0_valid = 1'b0;
        check("single_shift_busy", {7'd0, busy}, 8'd1);
        check("single_shift_valid", {7'd0, res_valid}, 8'd0);
        @(negedge clk);
        check("single_resp_valid", {7'd0, res_valid}, 8'd1);
        check("single_resp_data", res_data, 8'b0000_1000);
        check("single_resp_id", {7'd0, res_id}, 8'd0);
        @(negedge clk);
        check("single_idle_busy", {7'd0, busy}, 8'd0);
        check("single_idle_valid", {7'd0, res_valid}, 8'd0);

        // Contention from reset priority 0: ids 0,1,0,1 every 3 cycles.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hF0; req0_amt = 3'd1;
        req1_valid = 1'b1; req1_data = 8'hF0; req1_amt = 3'd2;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_res("rr", n);
            if (i > 0) check("rr_interval", n[7:0], 8'd3);
            check("rr_id", {7'd0, res_id}, (i % 2 == 0) ? 8'd0 : 8'd1);
            check("rr_data", res_data, (i % 2 == 0) ? 8'h78 : 8'h3C);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        // Backpressure: result held 5 cycles, no grants while stalled.
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hF0; req1_amt = 3'd3;
        wait_res("bp", n);
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {7'd0, res_valid}, 8'd1);
            check("bp_data", res_data, 8'h1E);
            check("bp_id", {7'd0, res_id}, 8'd1);
            check("bp_ready01", {6'd0, req1_ready, req0_ready}, 8'd0);
            check("bp_busy", {7'd0, busy}, 8'd1);
        end
        res_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("bp_release_busy", {7'd0, busy}, 8'd0);
        check("bp_release_valid", {7'd0, res_valid}, 8'd0);

        // Shift-amount boundaries and one more req0 op (leaves priority at 1).
        run_single("amt0", 1'b0, 8'hA5, 3'd0, 8'hA5);
        run_single("amt7", 1'b1, 8'b1000_0000, 3'd7, 8'b0000_0001);
        run_single("amt2", 1'b0, 8'h3C, 3'd2, 8'h0F);

        // Reset during SHIFT: outputs clear at once, priority back to RR_INIT.
        req0_valid = 1'b1; req0_data = 8'hAA; req0_amt = 3'd1;
        @(negedge clk);
        req0_valid = 1'b0;
        check("midrst_in_shift", {7'd0, busy}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", {7'd0, res_valid}, 8'd0);
        check("midrst_busy", {7'd0, busy}, 8'd0);
        check("midrst_data", res_data, 8'h00);
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = 3'd4;
        req1_valid = 1'b1; req1_data = 8'hFF; req1_amt = 3'd1;
        #1;
        check("midrst_held_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        rst = 1'b0;
        #1;
        check("midrst_grant0", {7'd0, req0_ready}, 8'd1);
        check("midrst_grant1", {7'd0, req1_ready}, 8'd0);
        wait_res("midrst", n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("midrst_res_id", {7'd0, res_id}, 8'd0);
        check("midrst_res_data", res_data, 8'h0F);
        @(negedge clk);

`ifdef BARREL_SHIFT_ARBITER_STATS_EN
        // Saturation: 300 req1 completions.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stat_rst1", stat1_cnt, 8'd0);
        req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 3'd0;
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) wait_res("stat", n);
        req1_valid = 1'b0;
        @(negedge clk);
        check("stat1_sat", stat1_cnt, 8'd255);
        check("stat0_zero", stat0_cnt, 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
